// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------
// cpu_pkg: opcodes, FSM states and instruction field positions. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_DIV_WAIT = 3'd4,
    ST_MEM      = 3'd5,
    ST_WB       = 3'd6,
    ST_HALT     = 3'd7
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_MULT  = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000011;
  localparam logic [5:0] OP_LOAD  = 6'b000100;
  localparam logic [5:0] OP_STORE = 6'b000101;
  localparam logic [5:0] OP_JMP   = 6'b000110;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int MADDR_LSB = 19;
  localparam int MREG_LSB  = 14;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OP_LSB +: 6];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------
// seq_divider: restoring unsigned divider, one quotient bit/cycle. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module seq_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic              div_zero
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   trial;
  logic              fits;

  always_comb begin
    trial = {rem, quotient[DATA_W-1]};
    fits  = (trial >= {1'b0, dvs});
  end

  // done marks the cycle in which the last quotient bit is computed,
  // so the quotient is final from the following cycle.
  assign done = busy && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
      div_zero <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= CW'(DATA_W);
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
      div_zero <= (divisor == '0);
    end else if (busy) begin
      rem      <= fits ? DATA_W'(trial - {1'b0, dvs}) : trial[DATA_W-1:0];
      quotient <= {quotient[DATA_W-2:0], fits};
      cnt      <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_cpu.sv
// ----------------------------------------------------------------------
// multi_cycle_cpu: FSM-sequenced CPU, unified memory, seq divider. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int MEM_DEPTH = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         ext_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] ext_addr,
  input  logic [DATA_W-1:0]            ext_wdata,
  output logic [DATA_W-1:0]            ext_rdata,
  input  logic [4:0]                   dbg_raddr,
  output logic [DATA_W-1:0]            dbg_rdata,
  output logic [$clog2(MEM_DEPTH)-1:0] pc,
  output logic                         halted,
  output logic                         illegal,
  output logic                         div_zero
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] mem  [MEM_DEPTH];
  logic [DATA_W-1:0] regs [NUM_REGS];

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] result;

  logic [5:0]        op;
  logic [RW-1:0]     rs_idx, rt_idx, rd_idx, mreg_idx, wb_idx;
  logic [AW-1:0]     maddr;
  logic [DATA_W-1:0] op_a, op_b, alu_out, wb_data;
  logic              div_start, div_done, div_by_zero;
  logic [DATA_W-1:0] div_q;
  logic              unused_bits;

  assign op       = opcode_of(ir);
  assign rs_idx   = ir[RS_LSB +: RW];
  assign rt_idx   = ir[RT_LSB +: RW];
  assign rd_idx   = ir[RD_LSB +: RW];
  assign mreg_idx = ir[MREG_LSB +: RW];
  assign maddr    = ir[MADDR_LSB +: AW];
  assign op_a     = regs[rs_idx];
  assign op_b     = regs[rt_idx];

  assign ext_rdata = mem[ext_addr];
  assign dbg_rdata = regs[dbg_raddr[RW-1:0]];

  assign unused_bits = ^{ir[10:0], dbg_raddr};

  assign div_start = (state == ST_DECODE) && (op == OP_DIV);

  seq_divider #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (op_a),
    .divisor  (op_b),
    .done     (div_done),
    .quotient (div_q),
    .div_zero (div_by_zero)
  );

  always_comb begin
    alu_out = op_a + op_b;
    case (op)
      OP_SUB:  alu_out = op_a - op_b;
      OP_MULT: alu_out = op_a * op_b;
      default: alu_out = op_a + op_b;
    endcase
  end

  assign wb_idx  = (op == OP_LOAD) ? mreg_idx : rd_idx;
  assign wb_data = (op == OP_DIV) ? div_q : result;

  // One write port: the load port only matters while the core is idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_IDLE && ext_we) begin
        mem[ext_addr] <= ext_wdata;
      end else if (state == ST_MEM && op == OP_STORE) begin
        mem[maddr] <= regs[mreg_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == ST_WB) begin
      regs[wb_idx] <= wb_data;
    end
  end

  // Every instruction completion is a boundary where run=0 parks the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir       <= '0;
      result   <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          ir    <= 32'(mem[pc]);
          pc    <= pc + AW'(1);
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          case (op)
            OP_ADD, OP_SUB, OP_MULT: state <= ST_EXEC;
            OP_DIV:                  state <= ST_DIV_WAIT;
            OP_LOAD, OP_STORE:       state <= ST_MEM;
            OP_JMP: begin
              pc    <= maddr;
              state <= run ? ST_FETCH : ST_IDLE;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
            default: begin
              halted  <= 1'b1;
              illegal <= 1'b1;
              state   <= ST_HALT;
            end
          endcase
        end
        ST_EXEC: begin
          result <= alu_out;
          state  <= ST_WB;
        end
        ST_DIV_WAIT: begin
          if (div_done) state <= ST_WB;
        end
        ST_MEM: begin
          if (op == OP_LOAD) begin
            result <= mem[maddr];
            state  <= ST_WB;
          end else begin
            state <= run ? ST_FETCH : ST_IDLE;
          end
        end
        ST_WB: begin
          if (op == OP_DIV && div_by_zero) div_zero <= 1'b1;
          state <= run ? ST_FETCH : ST_IDLE;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_cpu.sv
// ----------------------------------------------------------------------
// tb_multi_cycle_cpu: scoreboard bench for multi_cycle_cpu. Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_multi_cycle_cpu;

  localparam logic [5:0] T_ADD   = 6'b000000;
  localparam logic [5:0] T_SUB   = 6'b000001;
  localparam logic [5:0] T_MULT  = 6'b000010;
  localparam logic [5:0] T_DIV   = 6'b000011;
  localparam logic [5:0] T_LOAD  = 6'b000100;
  localparam logic [5:0] T_STORE = 6'b000101;
  localparam logic [5:0] T_JMP   = 6'b000110;
  localparam logic [5:0] T_HALT  = 6'b111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        ext_we = 1'b0;
  logic [6:0]  ext_addr = '0;
  logic [31:0] ext_wdata = '0;
  logic [31:0] ext_rdata;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic [6:0]  pc;
  logic        halted, illegal, div_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_mem;
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  multi_cycle_cpu dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .pc        (pc),
    .halted    (halted),
    .illegal   (illegal),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] mtype(input logic [5:0] op, input logic [6:0] a,
                                        input logic [4:0] r);
    return {op, a, r, 14'b0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset  = 1'b1;
    run    = 1'b0;
    ext_we = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    ext_addr  = a[6:0];
    ext_wdata = d;
    ext_we    = 1'b1;
    tick();
    ext_we = 1'b0;
  endtask

  task automatic peek_reg(input int r, output logic [31:0] v);
    dbg_raddr = r[4:0];
    #1;
    v = dbg_rdata;
  endtask

  task automatic peek_mem(input int a, output logic [31:0] v);
    ext_addr = a[6:0];
    #1;
    v = ext_rdata;
  endtask

  task automatic expect_item(input bit is_mem, input int idx, input logic [31:0] val);
    exp_t e;
    e.is_mem = is_mem;
    e.idx    = idx;
    e.val    = val;
    sb.push_back(e);
  endtask

  task automatic drain_sb(input string prefix);
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_mem) peek_mem(e.idx, got);
      else          peek_reg(e.idx, got);
      check($sformatf("%s_%s%0d", prefix, e.is_mem ? "mem" : "r", e.idx), got, e.val);
    end
  endtask

  task automatic wait_halt(input string tag, input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, {31'b0, halted}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;

    // Reset state
    do_reset();
    check("rst_pc", {25'b0, pc}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_divzero", {31'b0, div_zero}, 32'd0);
    for (int r = 0; r < 32; r++) begin
      peek_reg(r, v);
      check($sformatf("rst_r%0d", r), v, 32'd0);
    end

    // LOAD/LOAD/ADD/HALT with cycle-exact halt
    poke(64, 32'd7);
    poke(65, 32'd3);
    poke(0, mtype(T_LOAD, 7'd64, 5'd1));
    poke(1, mtype(T_LOAD, 7'd65, 5'd2));
    poke(2, rtype(T_ADD, 5'd1, 5'd2, 5'd3));
    poke(3, {T_HALT, 26'b0});
    expect_item(0, 1, 32'd7);
    expect_item(0, 2, 32'd3);
    expect_item(0, 3, 32'd10);
    run = 1'b1;
    repeat (14) tick();
    check("t1_halted_c13", {31'b0, halted}, 32'd0);
    tick();
    check("t1_halted_c14", {31'b0, halted}, 32'd1);
    check("t1_illegal", {31'b0, illegal}, 32'd0);
    check("t1_pc", {25'b0, pc}, 32'd4);
    drain_sb("t1");

    // DIV 100/7 lands exactly 35 cycles after its fetch
    do_reset();
    poke(64, 32'd100);
    poke(65, 32'd7);
    poke(0, mtype(T_LOAD, 7'd64, 5'd1));
    poke(1, mtype(T_LOAD, 7'd65, 5'd2));
    poke(2, rtype(T_DIV, 5'd1, 5'd2, 5'd3));
    poke(3, {T_HALT, 26'b0});
    run = 1'b1;
    repeat (43) tick();
    peek_reg(3, v);
    check("t2_div_early", v, 32'd0);
    tick();
    peek_reg(3, v);
    check("t2_div_ontime", v, 32'd14);
    check("t2_divzero", {31'b0, div_zero}, 32'd0);

    // Divide by zero, then wrap arithmetic, MULT, STORE, LOAD into R0
    do_reset();
    poke(64, 32'd100);
    poke(65, 32'd0);
    poke(0, mtype(T_LOAD, 7'd64, 5'd1));
    poke(1, mtype(T_LOAD, 7'd65, 5'd2));
    poke(2, rtype(T_DIV, 5'd1, 5'd2, 5'd3));
    poke(3, rtype(T_ADD, 5'd3, 5'd1, 5'd4));
    poke(4, rtype(T_SUB, 5'd2, 5'd1, 5'd5));
    poke(5, rtype(T_MULT, 5'd1, 5'd1, 5'd6));
    poke(6, mtype(T_STORE, 7'd66, 5'd4));
    poke(7, mtype(T_LOAD, 7'd66, 5'd0));
    poke(8, {T_HALT, 26'b0});
    expect_item(0, 3, 32'hFFFF_FFFF);
    expect_item(0, 4, 32'd99);
    expect_item(0, 5, 32'hFFFF_FF9C);
    expect_item(0, 6, 32'd10000);
    expect_item(0, 0, 32'd99);
    expect_item(1, 66, 32'd99);
    run = 1'b1;
    wait_halt("t3_halt", 300);
    check("t3_divzero", {31'b0, div_zero}, 32'd1);
    check("t3_illegal", {31'b0, illegal}, 32'd0);
    drain_sb("t3");
    do_reset();
    check("t3_divzero_cleared", {31'b0, div_zero}, 32'd0);
    peek_mem(66, v);
    check("t3_mem_kept", v, 32'd99);

    // JMP 127 then pc wraps after the fetch at 127
    do_reset();
    poke(0, mtype(T_JMP, 7'd127, 5'd0));
    poke(127, rtype(T_ADD, 5'd0, 5'd0, 5'd1));
    run = 1'b1;
    tick();
    tick();
    check("t4_pc_fetch0", {25'b0, pc}, 32'd1);
    tick();
    check("t4_pc_jmp", {25'b0, pc}, 32'd127);
    tick();
    check("t4_pc_wrap", {25'b0, pc}, 32'd0);

    // Reset in the 10th DIV_WAIT cycle aborts the divide
    do_reset();
    poke(64, 32'd100);
    poke(65, 32'd7);
    poke(0, mtype(T_LOAD, 7'd64, 5'd1));
    poke(1, mtype(T_LOAD, 7'd65, 5'd2));
    poke(2, rtype(T_DIV, 5'd1, 5'd2, 5'd3));
    poke(3, {T_HALT, 26'b0});
    run = 1'b1;
    repeat (20) tick();
    peek_reg(1, v);
    check("t5_r1_loaded", v, 32'd100);
    peek_reg(2, v);
    check("t5_r2_loaded", v, 32'd7);
    reset = 1'b1;
    run   = 1'b0;
    tick();
    reset = 1'b0;
    check("t5_pc", {25'b0, pc}, 32'd0);
    check("t5_halted", {31'b0, halted}, 32'd0);
    for (int r = 0; r < 32; r++) begin
      peek_reg(r, v);
      check($sformatf("t5_r%0d", r), v, 32'd0);
    end
    repeat (40) tick();
    peek_reg(3, v);
    check("t5_no_wb", v, 32'd0);
    check("t5_pc_idle", {25'b0, pc}, 32'd0);

    // Undefined opcode halts; HALT ignores run and ext_we
    do_reset();
    poke(100, 32'h55);
    poke(0, {6'b001111, 26'b0});
    run = 1'b1;
    repeat (3) tick();
    check("t6_illegal", {31'b0, illegal}, 32'd1);
    check("t6_halted", {31'b0, halted}, 32'd1);
    check("t6_pc", {25'b0, pc}, 32'd1);
    ext_addr  = 7'd100;
    ext_wdata = 32'hAA;
    ext_we    = 1'b1;
    repeat (20) tick();
    ext_we = 1'b0;
    check("t6_pc_frozen", {25'b0, pc}, 32'd1);
    check("t6_still_halted", {31'b0, halted}, 32'd1);
    peek_mem(100, v);
    check("t6_ext_we_ignored", v, 32'h55);
    do_reset();
    check("t6_halt_cleared", {31'b0, halted}, 32'd0);
    check("t6_illegal_cleared", {31'b0, illegal}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_cycle_cpu.md
MULTI_CYCLE_CPU -- requirements
Module: multi_cycle_cpu

Interface
REQ-001 Parameter DATA_W, default 32: register, ALU and memory word width (8..32).
REQ-002 Parameter NUM_REGS, default 32: register-file entries (2..32, power of two).
REQ-003 Parameter MEM_DEPTH, default 128: unified instruction/data words (2..128, power of two).
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port reset  in  1: synchronous, active-high reset.
REQ-006 Port run  in  1: 1 lets the core start or continue fetching; 0 stops it at the next instruction boundary.
REQ-007 Port ext_we, ext_addr[log2(MEM_DEPTH)], ext_wdata[DATA_W]  in: bench memory load port, honoured only in IDLE.
REQ-008 Port ext_rdata  out  DATA_W: mem[ext_addr], combinational, valid in any state.
REQ-009 Port dbg_raddr  in  5 / dbg_rdata  out  DATA_W: combinational register-file peek.
REQ-010 Port pc  out  log2(MEM_DEPTH): current program counter.
REQ-011 Ports halted, illegal, div_zero  out  1 each: sticky status flags.

Function
REQ-012 Instruction word is 32 bits. op=[31:25]? No: op=[31:26]. R-type: rs=[25:21], rt=[20:16], rd=[15:11]. M-type: addr=[25:19], reg=[18:14].
REQ-013 Opcodes: ADD 000000, SUB 000001, MULT 000010, DIV 000011, LOAD 000100, STORE 000101, JMP 000110 (target=addr field), HALT 111111.
REQ-014 Upper address bits beyond log2(MEM_DEPTH) and register bits beyond log2(NUM_REGS) are ignored.
REQ-015 FSM states: IDLE, FETCH, DECODE, EXEC, DIV_WAIT, MEM, WB, HALT.
REQ-016 IDLE->FETCH when run=1; FETCH->DECODE always; instruction register latched in FETCH.
REQ-017 DECODE: ADD/SUB/MULT->EXEC; DIV->DIV_WAIT; LOAD/STORE->MEM; JMP->FETCH (pc<=target); HALT or undefined->HALT.
REQ-018 EXEC->WB; MEM(LOAD)->WB; MEM(STORE)->FETCH after the write; DIV_WAIT->WB after exactly DATA_W cycles.
REQ-019 WB writes rd (or reg for LOAD), then goes to FETCH if run=1, else IDLE.
REQ-020 Latency: ADD/SUB/MULT/LOAD 4 cycles, STORE 3, JMP 2, DIV DATA_W+3.
REQ-021 pc increments by 1 in FETCH, modulo MEM_DEPTH; JMP overrides the increment.
REQ-022 ADD/SUB wrap modulo 2^DATA_W; MULT keeps the low DATA_W bits of the unsigned product; DIV is an unsigned quotient.
REQ-023 DIV by zero: result all-ones, div_zero set, execution continues.
REQ-024 Undefined opcode: illegal=1 and halted=1; HALT opcode: halted=1 only.
REQ-025 HALT is absorbing: only reset leaves it; run is ignored.
REQ-026 A STORE and an ext_we cannot collide, because ext_we is ignored outside IDLE.
REQ-027 All registers, including R0, are general purpose and writable.

Reset
REQ-028 Reset applies from any state, including mid-DIV_WAIT: state=IDLE, pc=0, all registers=0, flags=0, and the divider is aborted.
REQ-029 Memory contents are not cleared by reset.
REQ-030 Reset has priority over run and ext_we in the same cycle.

Structure
REQ-031 Package cpu_pkg holds the opcode constants, FSM state encodings and field bit positions.
REQ-032 Sub-module seq_divider performs restoring division, one quotient bit per cycle, with start, done, quotient and div_zero signals, and is instantiated once.
REQ-033 Memory is a single-port-per-cycle array plus a combinational ext read path, implemented inline.

Verification
REQ-034 Set mem[64]=7, mem[65]=3; run LOAD 64->R1, LOAD 65->R2, ADD R1+R2->R3, HALT -> R3=10, halted=1 after 14 cycles.
REQ-035 Set R1=100, R2=7; run DIV R1/R2->R3 -> R3=14 exactly 35 cycles after leaving IDLE (DATA_W=32).
REQ-036 Run DIV with R2=0 -> R3=0xFFFFFFFF, div_zero=1, next instruction still executes.
REQ-037 Place JMP 127 at 0 and ADD at 127 -> pc wraps from 127 to 0 after the fetch at 127.
REQ-038 Assert reset during DIV_WAIT cycle 10 -> next cycle state=IDLE, pc=0, dbg_rdata=0 for all registers, no write-back.
REQ-039 Execute opcode 001111 -> illegal=1, halted=1; pc stays frozen with run=1 for 20 cycles.
